mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data SRAM between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage RV32 pipeline.
- Grants at most one access per cycle and returns read data one cycle after grant.
- Drives stall requests to the hazard unit for the losing requester.
- Data-side priority with a bounded starvation guard for fetch.

Parameters:
P_DATA_WIDTH, 32, memory word and data bus width
P_ADDR_WIDTH, 10, byte address width of both requesters and the memory port
P_MAX_STREAK, 4, max consecutive data grants while fetch waits before fetch is forced (range 1..15)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_if_req  input  1  fetch read request, held until granted
i_if_addr  input  P_ADDR_WIDTH  fetch byte address, word aligned
o_if_gnt  output  1  fetch request accepted this cycle
o_if_rvalid  output  1  o_if_rdata valid (cycle after o_if_gnt)
o_if_rdata  output  P_DATA_WIDTH  instruction word
i_dm_req  input  1  data request, held until granted
i_dm_we  input  1  1 = store, 0 = load
i_dm_addr  input  P_ADDR_WIDTH  data byte address
i_dm_wdata  input  P_DATA_WIDTH  store data
i_dm_wstrb  input  P_DATA_WIDTH/8  store byte enables
o_dm_gnt  output  1  data request accepted this cycle
o_dm_rvalid  output  1  load data valid (cycle after load grant only)
o_dm_rdata  output  P_DATA_WIDTH  load data
o_stall_if  output  1  i_if_req & ~o_if_gnt (combinational)
o_stall_dm  output  1  i_dm_req & ~o_dm_gnt (combinational)
o_mem_en  output  1  SRAM access enable
o_mem_we  output  1  SRAM write enable
o_mem_addr  output  P_ADDR_WIDTH  SRAM byte address
o_mem_wdata  output  P_DATA_WIDTH  SRAM write data
o_mem_wstrb  output  P_DATA_WIDTH/8  SRAM byte enables; zero on reads
i_mem_rdata  input  P_DATA_WIDTH  SRAM read data, valid one cycle after a read enable

Behaviour:
- Reset (async assert, sync release): state IDLE, streak counter 0.
  - All gnt, rvalid, mem_en, mem_we = 0.
  - rdata outputs = 0.
- Grant decision (combinational, every cycle; new grants allowed in any state, so back-to-back accesses run at 1/cycle):
  - Only if_req: grant fetch.
  - Only dm_req: grant data.
  - Both and streak < P_MAX_STREAK: grant data.
  - Both and streak == P_MAX_STREAK: grant fetch.
- SRAM port drive:
  - o_mem_en = o_if_gnt | o_dm_gnt.
  - Address, wdata, wstrb and we are muxed from the granted side.
  - Idle cycles: o_mem_we = 0 and o_mem_wstrb = 0.
- Streak counter (4 bits):
  - Increments on a data grant while if_req is high and fetch is not granted.
  - Clears on a fetch grant or whenever if_req is low.
  - Saturates at P_MAX_STREAK.
- Response FSM states:
  - IDLE: no read in flight.
  - I_RESP: fetch read in flight.
  - D_RESP: load in flight.
- FSM transitions, evaluated each cycle from that cycle's grant:
  - Fetch grant -> I_RESP.
  - Load grant -> D_RESP.
  - Store grant or no grant -> IDLE.
- Response outputs:
  - In I_RESP: o_if_rvalid = 1, o_if_rdata = i_mem_rdata.
  - In D_RESP: o_dm_rvalid = 1, o_dm_rdata = i_mem_rdata.
  - rdata of a non-responding side holds its last value.
- Store timing:
  - A store completes at grant; no rvalid is produced.
  - A load to the same address granted the next cycle returns the new data, since the SRAM is write-first across cycles.
- Latency: read grant to rvalid is exactly 1 cycle; zero added latency when uncontended.
- Request drop: requesters must not drop req before gnt. If they do, no response is generated and the streak counter clears via the if_req rule.
- Reset mid-operation: an in-flight read is discarded and no rvalid is produced after reset release.
- Requests present in the same cycle that reset releases are arbitrated normally on that cycle.

Test Plan:
- Fetch-only stream, addrs 0x000, 0x004, 0x008 on consecutive cycles: o_if_gnt=1 each cycle; o_if_rvalid on cycles 1-3 with SRAM words at those addresses; o_stall_if=0 throughout.
- Simultaneous if_req (0x010) and dm load (0x100): data granted cycle 0, o_stall_if=1; fetch granted cycle 1; o_dm_rvalid cycle 1, o_if_rvalid cycle 2.
- Starvation guard, P_MAX_STREAK=4: fetch held high while data requests every cycle. Data granted cycles 0-3, fetch granted cycle 4 with o_stall_dm=1, data granted again cycle 5.
- Store 0xDEADBEEF with wstrb 4'b0011 to 0x200, then load 0x200 next cycle (old word 0x11223344): o_dm_rdata=0x1122BEEF; no rvalid on the store.
- Assert i_rst_n low one cycle after a fetch grant: no o_if_rvalid after release; all outputs 0 during reset; a new request is granted on the first cycle after release.
- Alternating fetch/load grants: o_if_rvalid and o_dm_rvalid never asserted in the same cycle; every grant-to-rvalid latency is 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM port between fetch and data, data-first with a fetch starvation guard
module mem_port_arbiter #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_MAX_STREAK = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_if_req,
  input  logic [P_ADDR_WIDTH-1:0]   i_if_addr,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic [P_DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                      i_dm_req,
  input  logic                      i_dm_we,
  input  logic [P_ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [P_DATA_WIDTH-1:0]   i_dm_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] i_dm_wstrb,
  output logic                      o_dm_gnt,
  output logic                      o_dm_rvalid,
  output logic [P_DATA_WIDTH-1:0]   o_dm_rdata,
  output logic                      o_stall_if,
  output logic                      o_stall_dm,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [P_ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [P_DATA_WIDTH/8-1:0] o_mem_wstrb,
  input  logic [P_DATA_WIDTH-1:0]   i_mem_rdata
);
  localparam logic [3:0] MAX = 4'(P_MAX_STREAK);
  typedef enum logic [1:0] {IDLE, I_RESP, D_RESP} state_t;
  state_t state;
  logic [3:0] streak;
  logic [P_DATA_WIDTH-1:0] if_hold, dm_hold;
  // fetch wins a contested cycle only once data has had its full streak
  assign o_if_gnt    = i_rst_n & i_if_req & (~i_dm_req | (streak == MAX));
  assign o_dm_gnt    = i_rst_n & i_dm_req & ~o_if_gnt;
  assign o_stall_if  = i_if_req & ~o_if_gnt;
  assign o_stall_dm  = i_dm_req & ~o_dm_gnt;
  assign o_mem_en    = o_if_gnt | o_dm_gnt;
  assign o_mem_we    = o_dm_gnt & i_dm_we;
  assign o_mem_addr  = o_if_gnt ? i_if_addr : i_dm_addr;
  assign o_mem_wdata = o_mem_we ? i_dm_wdata : '0;
  assign o_mem_wstrb = o_mem_we ? i_dm_wstrb : '0;
  assign o_if_rvalid = state == I_RESP;
  assign o_dm_rvalid = state == D_RESP;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_hold;
  assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : dm_hold;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      streak  <= '0;
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      state   <= o_if_gnt ? I_RESP : (o_dm_gnt & ~i_dm_we) ? D_RESP : IDLE;
      streak  <= (~i_if_req | o_if_gnt) ? 4'd0 : (o_dm_gnt & (streak != MAX)) ? streak + 4'd1 : streak;
      if (o_if_rvalid) if_hold <= i_mem_rdata;
      if (o_dm_rvalid) dm_hold <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a reference arbiter, memory image and response scoreboard
module tb_mem_port_arbiter;
  localparam int MS = 4;
  logic        i_clk = 0, i_rst_n = 1;
  logic        i_if_req = 0, i_dm_req = 0, i_dm_we = 0;
  logic [9:0]  i_if_addr = 0, i_dm_addr = 0;
  logic [31:0] i_dm_wdata = 0, i_mem_rdata = 0;
  logic [3:0]  i_dm_wstrb = 0;
  logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_stall_if, o_stall_dm, o_mem_en, o_mem_we;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_wdata;
  logic [9:0]  o_mem_addr;
  logic [3:0]  o_mem_wstrb;

  mem_port_arbiter #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(10), .P_MAX_STREAK(MS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata), .i_dm_wstrb(i_dm_wstrb),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_stall_if(o_stall_if), .o_stall_dm(o_stall_dm),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct { int c; logic [31:0] d; } exp_t;
  exp_t        if_q[$], dm_q[$];
  int          n_chk = 0, n_err = 0, cyc = 0, streak = 0;
  logic [31:0] sram[256], ref_mem[256];
  logic [31:0] last_if = 0, last_dm = 0;
  logic        f_req = 0, d_req = 0, d_we = 0, g_if = 0, g_dm = 0;
  logic [9:0]  f_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic [3:0]  d_wstrb = 0;

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory behind the port: one-cycle read latency, byte-enabled writes
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++) if (o_mem_wstrb[b]) sram[o_mem_addr[9:2]][8*b +: 8] = o_mem_wdata[8*b +: 8];
      end else i_mem_rdata <= sram[o_mem_addr[9:2]];
    end
  end

  // response monitor: every read grant must answer exactly one cycle later
  always @(posedge i_clk) begin
    exp_t e;
    cyc++;
    #3;
    if (!i_rst_n) begin
      last_if = 0;
      last_dm = 0;
    end else begin
      chk("rvalid_both", o_if_rvalid & o_dm_rvalid, 0);
      if (o_if_rvalid) begin
        if (if_q.size() == 0) chk("if_spurious_rvalid", 1, 0);
        else begin
          e = if_q.pop_front();
          chk("if_latency", cyc, e.c + 1);
          chk("if_rdata", o_if_rdata, e.d);
          last_if = e.d;
        end
      end else begin
        chk("if_rdata_hold", o_if_rdata, last_if);
        if (if_q.size() > 0 && if_q[0].c < cyc) begin
          chk("if_missing_rvalid", 0, 1);
          void'(if_q.pop_front());
        end
      end
      if (o_dm_rvalid) begin
        if (dm_q.size() == 0) chk("dm_spurious_rvalid", 1, 0);
        else begin
          e = dm_q.pop_front();
          chk("dm_latency", cyc, e.c + 1);
          chk("dm_rdata", o_dm_rdata, e.d);
          last_dm = e.d;
        end
      end else begin
        chk("dm_rdata_hold", o_dm_rdata, last_dm);
        if (dm_q.size() > 0 && dm_q[0].c < cyc) begin
          chk("dm_missing_rvalid", 0, 1);
          void'(dm_q.pop_front());
        end
      end
    end
  end

  // one cycle of traffic: drive pending requests, compare against the reference arbiter
  task automatic tick();
    logic ei, ed, fr;
    @(negedge i_clk);
    i_rst_n = 1; i_if_req = f_req; i_if_addr = f_addr;
    i_dm_req = d_req; i_dm_we = d_we; i_dm_addr = d_addr; i_dm_wdata = d_wdata; i_dm_wstrb = d_wstrb;
    #1;
    fr = f_req;
    ei = f_req && (!d_req || streak == MS);
    ed = d_req && !ei;
    chk("if_gnt", o_if_gnt, ei);
    chk("dm_gnt", o_dm_gnt, ed);
    chk("stall_if", o_stall_if, f_req && !ei);
    chk("stall_dm", o_stall_dm, d_req && !ed);
    chk("mem_ctl", {o_mem_en, o_mem_we, o_mem_wstrb}, {ei | ed, ed & d_we, (ed & d_we) ? d_wstrb : 4'h0});
    if (ei || ed) chk("mem_addr", o_mem_addr, ei ? f_addr : d_addr);
    if (ed && d_we) chk("mem_wdata", o_mem_wdata, d_wdata);
    if (ei) begin
      if_q.push_back('{c: cyc, d: ref_mem[f_addr[9:2]]});
      f_req = 0;
    end
    if (ed) begin
      if (d_we) begin
        for (int b = 0; b < 4; b++) if (d_wstrb[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end else dm_q.push_back('{c: cyc, d: ref_mem[d_addr[9:2]]});
      d_req = 0;
    end
    streak = (!fr || ei) ? 0 : ed ? ((streak + 1 > MS) ? MS : streak + 1) : streak;
    g_if = ei;
    g_dm = ed;
  endtask

  task automatic rst_cycle();
    @(negedge i_clk);
    i_rst_n = 0; i_if_req = 0; i_dm_req = 0;
    f_req = 0; d_req = 0; streak = 0;
    if_q.delete(); dm_q.delete();
    #1;
    chk("rst_ctl", {o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_en, o_mem_we}, 0);
    chk("rst_rdata", {o_if_rdata, o_dm_rdata}, 0);
  endtask

  task automatic set_fetch(input logic [9:0] a);
    f_req = 1; f_addr = a;
  endtask

  task automatic set_data(input logic we, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] ws);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
  endtask

  task automatic rand_data();
    set_data(1'($urandom_range(1)), {8'($urandom_range(31)), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
  endtask

  initial begin
    int nd;
    logic got;
    for (int i = 0; i < 256; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[128] = 32'h11223344;
    ref_mem[128] = 32'h11223344;
    #1 i_rst_n = 0;
    repeat (3) rst_cycle();
    // fetch-only stream
    for (int k = 0; k < 3; k++) begin
      set_fetch(10'(4 * k));
      tick();
    end
    repeat (2) tick();
    // contested fetch and load
    set_fetch(10'h010);
    set_data(0, 10'h100, 0, 0);
    repeat (3) tick();
    // starvation guard: data requests every cycle while fetch waits
    set_fetch(10'h040);
    nd = 0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (!d_req) rand_data();
      tick();
      if (g_if && !got) begin
        got = 1;
        chk("starve_data_grants", nd, MS);
      end else if (!got && g_dm) nd++;
    end
    chk("starve_fetch_granted", got, 1);
    d_req = 0;
    repeat (2) tick();
    // partial store then load of same word
    set_data(1, 10'h200, 32'hDEADBEEF, 4'b0011);
    tick();
    set_data(0, 10'h200, 0, 0);
    tick();
    repeat (2) tick();
    // reset while a fetch read is in flight
    set_fetch(10'h020);
    tick();
    #1 i_rst_n = 0;
    if_q.delete();
    dm_q.delete();
    repeat (2) rst_cycle();
    set_fetch(10'h024);
    tick();
    chk("post_rst_gnt", g_if, 1);
    repeat (2) tick();
    // random mixed traffic
    for (int k = 0; k < 400; k++) begin
      if (!f_req && $urandom_range(99) < 60) set_fetch({8'($urandom_range(31)), 2'b00});
      if (!d_req && $urandom_range(99) < 60) rand_data();
      tick();
    end
    f_req = 0;
    d_req = 0;
    repeat (3) tick();
    chk("if_q_drained", if_q.size(), 0);
    chk("dm_q_drained", dm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
